// File: rtl/dmem_bytelane_ctrl_if.sv
// Request/response bundle between the memory stage (master) and dmem_bytelane_ctrl (slave).
interface dmem_bytelane_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bytelane_ctrl.sv
// Byte-addressed, size-aware data memory with post-reset clear sweep and 1-cycle registered response.
// Optional macro DMEM_BOUNDS_CHECK_EN flags word indices >= DEPTH instead of wrapping.
module dmem_bytelane_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_bytelane_ctrl_if.slave  bus,
  output logic                 init_done
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LOW_W = OFF_W + IDX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    sweep_q, sweep_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                init_done_q, init_done_d;
  logic                req_ready_c;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [IDX_W-1:0]    idx;
  logic [OFF_W+2:0]    shamt;
  logic [3:0]          nbytes;
  logic                misalign, oversize, range_err, err;
  logic [DATA_W-1:0]   lane_mask, rd_word, shifted, load_val, wr_mask, wr_word;
  logic                sign;

`ifndef DMEM_BOUNDS_CHECK_EN
  // Upper address bits are don't-care when the index silently wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:LOW_W];
`endif

  // Request decode: lane masks, load extraction and store merge.
  always_comb begin
    idx      = bus.req_addr[OFF_W +: IDX_W];
    shamt    = {bus.req_addr[OFF_W-1:0], 3'b000};
    nbytes   = 4'(1) << bus.req_size;
    oversize = 32'(nbytes) > NB;
    misalign = 1'b0;
    case (bus.req_size)
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      2'd3:    misalign = |bus.req_addr[2:0];
      default: misalign = 1'b0;
    endcase
`ifdef DMEM_BOUNDS_CHECK_EN
    range_err = |bus.req_addr[ADDR_W-1:LOW_W];
`else
    range_err = 1'b0;
`endif
    err = misalign | oversize | range_err;

    rd_word   = mem[idx];
    shifted   = rd_word >> shamt;
    lane_mask = '0;
    sign      = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      lane_mask[i*8 +: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
      if (i + 1 == int'(nbytes)) sign = shifted[i*8+7];
    end
    load_val = (shifted & lane_mask) |
               ((!bus.req_unsigned && sign) ? ~lane_mask : '0);
    wr_mask  = lane_mask << shamt;
    wr_word  = (rd_word & ~wr_mask) | ((bus.req_wdata << shamt) & wr_mask);
  end

  // Next-state, response and write-port control.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    init_done_d  = init_done_q;
    req_ready_c  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = idx;
    mem_wdata    = wr_word;

    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(DEPTH - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        req_ready_c = !resp_valid_q || bus.resp_ready;
        if (resp_valid_q && bus.resp_ready) resp_valid_d = 1'b0;
        if (bus.req_valid && req_ready_c) begin
          resp_valid_d = 1'b1;
          resp_err_d   = err;
          resp_rdata_d = (err || bus.req_write) ? '0 : load_val;
          mem_we       = bus.req_write && !err;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      init_done_q  <= init_done_d;
    end
  end

  // Storage array is cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign init_done      = init_done_q;
endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Bench for dmem_bytelane_ctrl: directed vector table, multi-cycle sequences, random traffic vs byte-array model.
module tb_dmem_bytelane_ctrl;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  dmem_bytelane_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus_if ();

  dmem_bytelane_ctrl #(.DATA_W(64), .DEPTH(DEPTH), .ADDR_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .init_done (init_done)
  );

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [63:0] a;
    logic [63:0] wd;
    logic        e;
    logic [63:0] r;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  mem_m [DEPTH*8];

  function automatic vec_t mk(logic w, logic [1:0] sz, logic u, logic [63:0] a,
                              logic [63:0] wd, logic e, logic [63:0] r);
    vec_t v;
    v.w = w; v.sz = sz; v.u = u; v.a = a; v.wd = wd; v.e = e; v.r = r;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: flat byte array, little-endian, address wraps over DEPTH*8 bytes.
  task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [63:0] a,
                       input logic [63:0] wd, output logic e, output logic [63:0] r);
    int nbytes;
    int base;
    nbytes = 1 << sz;
    e = (a % 64'(nbytes)) != 0;
`ifdef DMEM_BOUNDS_CHECK_EN
    if ((a >> 3) >= 64'(DEPTH)) e = 1'b1;
`endif
    r = '0;
    if (e) return;
    base = int'(a % 64'(DEPTH*8));
    if (w) begin
      for (int i = 0; i < nbytes; i++) mem_m[base+i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nbytes; i++) r[8*i +: 8] = mem_m[base+i];
      if (!u && r[8*nbytes-1])
        for (int i = nbytes; i < 8; i++) r[8*i +: 8] = 8'hFF;
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] wd);
    bus_if.req_valid    = 1'b1;
    bus_if.req_write    = w;
    bus_if.req_size     = sz;
    bus_if.req_unsigned = u;
    bus_if.req_addr     = a;
    bus_if.req_wdata    = wd;
  endtask

  // One transaction; optionally stall the consumer for `hold` cycles afterwards.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [63:0] a,
                        input logic [63:0] wd, input int hold, output logic e, output logic [63:0] r);
    int n;
    drive(w, sz, u, a, wd);
    bus_if.resp_ready = 1'b1;
    #1;
    n = 0;
    while (!bus_if.req_ready && n < 64) begin step(); n++; end
    if (!bus_if.req_ready) check("req_ready_timeout", 64'(bus_if.req_ready), 64'd1);
    step();
    bus_if.req_valid = 1'b0;
    e = bus_if.resp_err;
    r = bus_if.resp_rdata;
    check("resp_valid", 64'(bus_if.resp_valid), 64'd1);
    if (hold > 0) begin
      bus_if.resp_ready = 1'b0;
      repeat (hold) step();
      check("hold_stable", {bus_if.req_ready, bus_if.resp_valid, bus_if.resp_err, bus_if.resp_rdata[60:0]},
            {1'b0, 1'b1, e, r[60:0]});
      check("hold_rdata_hi", 64'(bus_if.resp_rdata[63:61]), 64'(r[63:61]));
      bus_if.resp_ready = 1'b1;
    end
  endtask

  task automatic wait_init(input string nm);
    int  n;
    logic bad_ready;
    n = 0;
    bad_ready = 1'b0;
    while (!init_done && n < 5000) begin
      if (bus_if.req_ready) bad_ready = 1'b1;
      step();
      n++;
    end
    check({nm, "_cycles"}, 64'(n), 64'd1024);
    check({nm, "_ready_low"}, 64'(bad_ready), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        e, me;
    logic [63:0] r, mr, exp1, exp2;
    logic [1:0]  sz;
    logic [63:0] a;
    int          sel;

    foreach (mem_m[i]) mem_m[i] = 8'h00;
    bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_size = 2'd0;
    bus_if.req_unsigned = 1'b0; bus_if.req_addr = '0; bus_if.req_wdata = '0;
    bus_if.resp_ready = 1'b1;

    // Reset state and sweep length
    step();
    check("rst_state", {59'd0, bus_if.resp_valid, bus_if.resp_err, init_done, bus_if.req_ready, 1'b0}, 64'd0);
    check("rst_rdata", bus_if.resp_rdata, 64'd0);
    reset = 1'b0;
    wait_init("init1");

    tbl.push_back(mk(0, 3, 0, 64'h1F8, 0, 0, 64'h0));
    tbl.push_back(mk(1, 3, 0, 64'h40, 64'h1122334455667788, 0, 64'h0));
    tbl.push_back(mk(1, 0, 0, 64'h43, 64'h123456789ABCDEAA, 0, 64'h0));
    tbl.push_back(mk(0, 3, 0, 64'h40, 0, 0, 64'h11223344AA667788));
    tbl.push_back(mk(0, 0, 0, 64'h43, 0, 0, 64'hFFFFFFFFFFFFFFAA));
    tbl.push_back(mk(0, 0, 1, 64'h43, 0, 0, 64'h00000000000000AA));
    tbl.push_back(mk(1, 1, 0, 64'h82, 64'hFFFF000000008001, 0, 64'h0));
    tbl.push_back(mk(0, 1, 0, 64'h82, 0, 0, 64'hFFFFFFFFFFFF8001));
    tbl.push_back(mk(0, 1, 1, 64'h82, 0, 0, 64'h0000000000008001));
    tbl.push_back(mk(0, 2, 0, 64'h82, 0, 1, 64'h0));
    tbl.push_back(mk(1, 1, 0, 64'h81, 64'h1234, 1, 64'h0));
    tbl.push_back(mk(0, 3, 0, 64'h80, 0, 0, 64'h0000000080010000));
    tbl.push_back(mk(0, 2, 0, 64'h80, 0, 0, 64'hFFFFFFFF80010000));
    tbl.push_back(mk(1, 2, 0, 64'h84, 64'h55555555DEADBEEF, 0, 64'h0));
    tbl.push_back(mk(0, 3, 1, 64'h80, 0, 0, 64'hDEADBEEF80010000));
    tbl.push_back(mk(0, 3, 0, 64'h44, 0, 1, 64'h0));
`ifdef DMEM_BOUNDS_CHECK_EN
    tbl.push_back(mk(1, 3, 0, 64'h2000, 64'hCAFEF00D12345678, 1, 64'h0));
    tbl.push_back(mk(0, 3, 0, 64'h0, 0, 0, 64'h0));
`else
    tbl.push_back(mk(1, 3, 0, 64'h2000, 64'hCAFEF00D12345678, 0, 64'h0));
    tbl.push_back(mk(0, 3, 0, 64'h0, 0, 0, 64'hCAFEF00D12345678));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, 0, e, r);
      model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, me, mr);
      check($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].e));
      check($sformatf("tbl%0d_rdata", i), r, tbl[i].r);
    end

    // Back-to-back loads under consumer backpressure
    step();
    model(0, 3, 0, 64'h40, 0, me, exp1);
    model(0, 3, 0, 64'h80, 0, me, exp2);
    drive(0, 3, 0, 64'h40, 0);
    bus_if.resp_ready = 1'b0;
    #1;
    check("bp_ready_first", 64'(bus_if.req_ready), 64'd1);
    step();
    drive(0, 3, 0, 64'h80, 0);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold%0d", k), {bus_if.req_ready, bus_if.resp_valid, 62'd0}, {1'b0, 1'b1, 62'd0});
      check($sformatf("bp_data%0d", k), bus_if.resp_rdata, exp1);
      step();
    end
    bus_if.resp_ready = 1'b1;
    #1;
    check("bp_ready_release", 64'(bus_if.req_ready), 64'd1);
    step();
    bus_if.req_valid = 1'b0;
    check("bp_second_valid", 64'(bus_if.resp_valid), 64'd1);
    check("bp_second_data", bus_if.resp_rdata, exp2);
    step();
    check("bp_no_dup", 64'(bus_if.resp_valid), 64'd0);

    // Reset drops a pending response, then reset again mid-sweep
    drive(0, 3, 0, 64'h40, 0);
    bus_if.resp_ready = 1'b0;
    #1;
    step();
    bus_if.req_valid = 1'b0;
    check("rst_pending_before", 64'(bus_if.resp_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_pending_drop", {bus_if.resp_valid, init_done, bus_if.req_ready}, 3'b000);
    check("rst_pending_rdata", bus_if.resp_rdata, 64'd0);
    bus_if.resp_ready = 1'b1;
    repeat (500) step();
    check("mid_sweep_busy", {init_done, bus_if.req_ready}, 2'b00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init("init2");
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    do_req(0, 3, 0, 64'h40, 0, 0, e, r);
    check("cleared_after_sweep", r, 64'd0);

    // Random traffic against the byte-array model
    for (int t = 0; t < 600; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 64'($urandom_range(0, 511));
      else if (sel < 9) a = 64'h2000 + 64'($urandom_range(0, 511));
      else              a = {$urandom, $urandom};
      sz = 2'($urandom_range(0, 3));
      drive(1'b0, sz, 1'b0, a, 0);
      bus_if.req_valid = 1'b0;
      begin
        logic        w, u;
        logic [63:0] wd;
        int          hold;
        w    = 1'($urandom_range(0, 1));
        u    = 1'($urandom_range(0, 1));
        wd   = {$urandom, $urandom};
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        model(w, sz, u, a, wd, me, mr);
        do_req(w, sz, u, a, wd, hold, e, r);
        check($sformatf("rnd%0d_err", t), 64'(e), 64'(me));
        check($sformatf("rnd%0d_rdata", t), r, mr);
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
